count_capture_74: RTL and testbench

Downstream consumer of the dual 4-bit binary counter pair. It takes both counter nibbles, which run on their own pin clocks and are asynchronous to `CLK`, into the `CLK` domain and debounces them into stable values. It flags target-match and wrap events, and on request serialises a snapshot of both nibbles as one 8-bit frame for readback logic or a pin.

---
 rtl/count_capture_74.sv | 173 +++++++++++++++++
 tb/tb_count_capture_74.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_capture_74.sv
// rtl/count_capture_74.sv - debounced capture of a dual 4-bit counter with match/wrap events and a serial snapshot frame
module count_capture_74 #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_CNT  = 2,
  parameter logic [3:0]  TARGET_A    = 4'd9,
  parameter logic [3:0]  TARGET_B    = 4'd9,
  parameter bit          MSB_FIRST   = 1'b1
) (
  input  logic       CLK,
  input  logic       nCLR,
  input  logic [3:0] CNT_A,
  input  logic [3:0] CNT_B,
  input  logic       CAP,
  output logic [3:0] STABLE_A,
  output logic [3:0] STABLE_B,
  output logic       A_MATCH,
  output logic       B_MATCH,
  output logic       A_WRAP,
  output logic       B_WRAP,
  output logic       SDO,
  output logic       SFRAME,
  output logic       BUSY
);

  localparam int unsigned    RUN_W    = $clog2(STABLE_CNT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STABLE_CNT);
  // The current sample counts as one, so STABLE_CNT-1 prior matches suffice.
  localparam logic [RUN_W-1:0] RUN_NEED = RUN_W'(STABLE_CNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Channel 0 is counter A, channel 1 is counter B.
  logic [3:0]       cnt_in   [2];
  logic [3:0]       target   [2];
  logic [3:0]       sync_q   [2][SYNC_STAGES];
  logic [3:0]       s_val    [2];
  logic [3:0]       hist_q   [2];
  logic [3:0]       stable_q [2];
  logic [RUN_W-1:0] run_q    [2];
  logic [RUN_W-1:0] run_nxt  [2];
  logic             upd      [2];
  logic             match_q  [2];
  logic             wrap_q   [2];

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       cap_hist;

  assign cnt_in[0] = CNT_A;
  assign cnt_in[1] = CNT_B;
  assign target[0] = TARGET_A;
  assign target[1] = TARGET_B;

  assign STABLE_A = stable_q[0];
  assign STABLE_B = stable_q[1];
  assign A_MATCH  = match_q[0];
  assign B_MATCH  = match_q[1];
  assign A_WRAP   = wrap_q[0];
  assign B_WRAP   = wrap_q[1];

  // Synchroniser chains bringing both asynchronous nibbles into the CLK domain.
  always_ff @(posedge CLK) begin
    if (!nCLR) begin
      for (int ch = 0; ch < 2; ch++) begin
        for (int i = 0; i < int'(SYNC_STAGES); i++) begin
          sync_q[ch][i] <= 4'd0;
        end
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        sync_q[ch][0] <= cnt_in[ch];
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
          sync_q[ch][i] <= sync_q[ch][i-1];
        end
      end
    end
  end

  // Run-length of identical synchronised samples and the resulting update strobe.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      s_val[ch] = sync_q[ch][SYNC_STAGES-1];
      if (s_val[ch] != hist_q[ch]) begin
        run_nxt[ch] = '0;
      end else if (run_q[ch] == RUN_MAX) begin
        run_nxt[ch] = run_q[ch];
      end else begin
        run_nxt[ch] = run_q[ch] + RUN_W'(1);
      end
      upd[ch] = (run_nxt[ch] >= RUN_NEED);
    end
  end

  // Debounce filter: commit settled values and raise one-cycle match/wrap events on change.
  always_ff @(posedge CLK) begin
    if (!nCLR) begin
      for (int ch = 0; ch < 2; ch++) begin
        hist_q[ch]   <= 4'd0;
        run_q[ch]    <= '0;
        stable_q[ch] <= 4'd0;
        match_q[ch]  <= 1'b0;
        wrap_q[ch]   <= 1'b0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        hist_q[ch]  <= s_val[ch];
        run_q[ch]   <= run_nxt[ch];
        match_q[ch] <= 1'b0;
        wrap_q[ch]  <= 1'b0;
        if (upd[ch] && (s_val[ch] != stable_q[ch])) begin
          stable_q[ch] <= s_val[ch];
          match_q[ch]  <= (s_val[ch] == target[ch]);
          wrap_q[ch]   <= (stable_q[ch] == 4'd15) && (s_val[ch] == 4'd0);
        end
      end
    end
  end

  // Capture FSM: a CAP rising edge in IDLE snapshots {B,A} and shifts it out over 8 cycles.
  always_ff @(posedge CLK) begin
    if (!nCLR) begin
      state    <= IDLE;
      shreg    <= 8'd0;
      bit_cnt  <= 3'd0;
      cap_hist <= 1'b1;
      SDO      <= 1'b0;
      SFRAME   <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      cap_hist <= CAP;
      case (state)
        IDLE: begin
          SDO    <= 1'b0;
          SFRAME <= 1'b0;
          BUSY   <= 1'b0;
          if (CAP && !cap_hist) begin
            shreg   <= {stable_q[1], stable_q[0]};
            bit_cnt <= 3'd0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          SDO     <= MSB_FIRST ? shreg[7] : shreg[0];
          shreg   <= MSB_FIRST ? {shreg[6:0], 1'b0} : {1'b0, shreg[7:1]};
          SFRAME  <= 1'b1;
          BUSY    <= 1'b1;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state <= DONE;
          end
        end
        DONE: begin
          SDO    <= 1'b0;
          SFRAME <= 1'b0;
          BUSY   <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          SDO    <= 1'b0;
          SFRAME <= 1'b0;
          BUSY   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_capture_74.sv
// tb/tb_count_capture_74.sv - self-checking bench for count_capture_74
module tb_count_capture_74;

  localparam int SYNC  = 2;
  localparam int STB   = 2;
  localparam int DEPTH = SYNC + STB;

  logic       CLK  = 1'b0;
  logic       nCLR = 1'b0;
  logic       CAP  = 1'b1;
  logic [3:0] CNT_A = 4'd5;
  logic [3:0] CNT_B = 4'd5;

  logic [3:0] m_stable_a, m_stable_b, l_stable_a, l_stable_b;
  logic m_a_match, m_b_match, m_a_wrap, m_b_wrap, m_sdo, m_sframe, m_busy;
  logic l_a_match, l_b_match, l_a_wrap, l_b_wrap, l_sdo, l_sframe, l_busy;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  count_capture_74 u_msb (
    .CLK(CLK), .nCLR(nCLR), .CNT_A(CNT_A), .CNT_B(CNT_B), .CAP(CAP),
    .STABLE_A(m_stable_a), .STABLE_B(m_stable_b),
    .A_MATCH(m_a_match), .B_MATCH(m_b_match), .A_WRAP(m_a_wrap), .B_WRAP(m_b_wrap),
    .SDO(m_sdo), .SFRAME(m_sframe), .BUSY(m_busy)
  );

  count_capture_74 #(.TARGET_B(4'd0), .MSB_FIRST(1'b0)) u_lsb (
    .CLK(CLK), .nCLR(nCLR), .CNT_A(CNT_A), .CNT_B(CNT_B), .CAP(CAP),
    .STABLE_A(l_stable_a), .STABLE_B(l_stable_b),
    .A_MATCH(l_a_match), .B_MATCH(l_b_match), .A_WRAP(l_a_wrap), .B_WRAP(l_b_wrap),
    .SDO(l_sdo), .SFRAME(l_sframe), .BUSY(l_busy)
  );

  // Model state: sampled input history, expected stable values and events, frame age.
  logic [3:0] win_a [DEPTH];
  logic [3:0] win_b [DEPTH];
  logic [3:0] e_sa = 4'd0, e_sb = 4'd0;
  logic e_am = 1'b0, e_aw = 1'b0, e_bm9 = 1'b0, e_bm0 = 1'b0, e_bw = 1'b0;
  int         age = -1;
  logic       cap_prev = 1'b1;
  logic [7:0] snap = 8'd0;
  logic       chk_en = 1'b0;

  // Observation counters used by the hand-computed checks.
  int         sframe_cnt = 0, busy_cnt = 0, a_match_cnt = 0, b_wrap_cnt = 0;
  int         lb_match_cnt = 0, lb_wrap_cnt = 0;
  logic [7:0] seq_m = 8'd0, seq_l = 8'd0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a value is presented once it was the input at STB consecutive
  // edges, SYNC edges ago; frames are tracked by edges elapsed since the accepted CAP edge.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      win_a[i] = 4'd0;
      win_b[i] = 4'd0;
    end
    forever begin
      @(posedge CLK);
      if (!nCLR) begin
        for (int i = 0; i < DEPTH; i++) begin
          win_a[i] = 4'd0;
          win_b[i] = 4'd0;
        end
        e_sa = 4'd0; e_sb = 4'd0;
        e_am = 1'b0; e_aw = 1'b0; e_bm9 = 1'b0; e_bm0 = 1'b0; e_bw = 1'b0;
        age = -1;
        cap_prev = 1'b1;
        chk_en = 1'b1;
      end else begin
        if (age >= 0) age++;
        if (age == 10) age = -1;
        if (age == -1 && CAP && !cap_prev) begin
          age = 0;
          snap = {e_sb, e_sa};
        end
        cap_prev = CAP;
        for (int i = DEPTH - 1; i > 0; i--) begin
          win_a[i] = win_a[i-1];
          win_b[i] = win_b[i-1];
        end
        win_a[0] = CNT_A;
        win_b[0] = CNT_B;
        e_am = 1'b0; e_aw = 1'b0; e_bm9 = 1'b0; e_bm0 = 1'b0; e_bw = 1'b0;
        begin
          logic same_a, same_b;
          same_a = 1'b1;
          same_b = 1'b1;
          for (int i = SYNC + 1; i < DEPTH; i++) begin
            if (win_a[i] != win_a[SYNC]) same_a = 1'b0;
            if (win_b[i] != win_b[SYNC]) same_b = 1'b0;
          end
          if (same_a && win_a[SYNC] != e_sa) begin
            e_am = (win_a[SYNC] == 4'd9);
            e_aw = (e_sa == 4'd15) && (win_a[SYNC] == 4'd0);
            e_sa = win_a[SYNC];
          end
          if (same_b && win_b[SYNC] != e_sb) begin
            e_bm9 = (win_b[SYNC] == 4'd9);
            e_bm0 = (win_b[SYNC] == 4'd0);
            e_bw  = (e_sb == 4'd15) && (win_b[SYNC] == 4'd0);
            e_sb  = win_b[SYNC];
          end
        end
      end
    end
  end

  // Compare process: every falling edge after the first reset edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        logic in_frame, e_busy, e_sdo_m, e_sdo_l;
        in_frame = (age >= 1 && age <= 8);
        e_busy   = (age >= 1 && age <= 9);
        e_sdo_m  = in_frame ? snap[8 - age] : 1'b0;
        e_sdo_l  = in_frame ? snap[age - 1] : 1'b0;
        check("m_stable_a", {4'd0, m_stable_a}, {4'd0, e_sa});
        check("m_stable_b", {4'd0, m_stable_b}, {4'd0, e_sb});
        check("m_a_match", {7'd0, m_a_match}, {7'd0, e_am});
        check("m_a_wrap", {7'd0, m_a_wrap}, {7'd0, e_aw});
        check("m_b_match", {7'd0, m_b_match}, {7'd0, e_bm9});
        check("m_b_wrap", {7'd0, m_b_wrap}, {7'd0, e_bw});
        check("m_sdo", {7'd0, m_sdo}, {7'd0, e_sdo_m});
        check("m_sframe", {7'd0, m_sframe}, {7'd0, in_frame});
        check("m_busy", {7'd0, m_busy}, {7'd0, e_busy});
        check("l_stable_a", {4'd0, l_stable_a}, {4'd0, e_sa});
        check("l_stable_b", {4'd0, l_stable_b}, {4'd0, e_sb});
        check("l_a_match", {7'd0, l_a_match}, {7'd0, e_am});
        check("l_b_match", {7'd0, l_b_match}, {7'd0, e_bm0});
        check("l_b_wrap", {7'd0, l_b_wrap}, {7'd0, e_bw});
        check("l_sdo", {7'd0, l_sdo}, {7'd0, e_sdo_l});
        check("l_sframe", {7'd0, l_sframe}, {7'd0, in_frame});
        check("l_busy", {7'd0, l_busy}, {7'd0, e_busy});
      end
      if (m_sframe === 1'b1) begin
        sframe_cnt++;
        seq_m = {seq_m[6:0], m_sdo};
      end
      if (l_sframe === 1'b1) seq_l = {seq_l[6:0], l_sdo};
      if (m_busy === 1'b1) busy_cnt++;
      if (m_a_match === 1'b1) a_match_cnt++;
      if (m_b_wrap === 1'b1) b_wrap_cnt++;
      if (l_b_match === 1'b1) lb_match_cnt++;
      if (l_b_wrap === 1'b1) lb_wrap_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
    #2;
  endtask

  task automatic clr();
    sframe_cnt = 0; busy_cnt = 0; a_match_cnt = 0; b_wrap_cnt = 0;
    lb_match_cnt = 0; lb_wrap_cnt = 0; seq_m = 8'd0; seq_l = 8'd0;
  endtask

  task automatic cap_pulse();
    CAP = 1'b1;
    step(1);
    CAP = 1'b0;
  endtask

  // Directed stimulus with hand-computed expectations.
  initial begin
    // Reset with CAP held high and both counters at 5.
    step(3);
    check("rst_stable_a", {4'd0, m_stable_a}, 8'd0);
    check("rst_busy", {7'd0, m_busy}, 8'd0);
    nCLR = 1'b1;
    clr();
    step(3);
    check("post_rst_k2_stable_a", {4'd0, m_stable_a}, 8'd0);
    step(1);
    check("post_rst_k3_stable_a", {4'd0, m_stable_a}, 8'd5);
    check("post_rst_k3_stable_b", {4'd0, m_stable_b}, 8'd5);
    step(4);
    check("no_frame_after_rst", 8'(busy_cnt), 8'd0);
    CAP = 1'b0;

    // Filter: one-cycle glitch is rejected, a held change lands after 3 edges.
    CNT_A = 4'd3;
    step(6);
    check("filter_base", {4'd0, m_stable_a}, 8'd3);
    CNT_A = 4'd7;
    step(1);
    CNT_A = 4'd3;
    step(6);
    check("filter_glitch", {4'd0, m_stable_a}, 8'd3);
    CNT_A = 4'd7;
    step(3);
    check("filter_k2", {4'd0, m_stable_a}, 8'd3);
    step(1);
    check("filter_k3", {4'd0, m_stable_a}, 8'd7);

    // Events.
    CNT_A = 4'd8;
    step(6);
    clr();
    CNT_A = 4'd9;
    step(10);
    check("a_match_once", 8'(a_match_cnt), 8'd1);
    CNT_B = 4'd15;
    step(6);
    clr();
    CNT_B = 4'd0;
    step(6);
    check("b_wrap_15_0", 8'(b_wrap_cnt), 8'd1);
    check("l_b_wrap_15_0", 8'(lb_wrap_cnt), 8'd1);
    check("l_b_match_t0", 8'(lb_match_cnt), 8'd1);
    CNT_B = 4'd14;
    step(6);
    clr();
    CNT_B = 4'd0;
    step(6);
    check("b_nowrap_14_0", 8'(b_wrap_cnt), 8'd0);
    check("l_b_match_14_0", 8'(lb_match_cnt), 8'd1);

    // Frame with {B,A} = 0xA5.
    CNT_A = 4'd5;
    CNT_B = 4'd10;
    step(6);
    clr();
    cap_pulse();
    step(12);
    check("frame_msb_seq", seq_m, 8'hA5);
    check("frame_lsb_seq", seq_l, 8'hA5);
    check("frame_sframe_cycles", 8'(sframe_cnt), 8'd8);
    check("frame_busy_cycles", 8'(busy_cnt), 8'd9);

    // CAP edge three cycles into a frame is ignored.
    clr();
    cap_pulse();
    step(2);
    cap_pulse();
    step(12);
    check("busy_ignore_sframe", 8'(sframe_cnt), 8'd8);
    check("busy_ignore_busy", 8'(busy_cnt), 8'd9);

    // A CAP edge exactly at n+10 starts a new frame.
    clr();
    cap_pulse();
    step(9);
    cap_pulse();
    step(12);
    check("n10_sframe", 8'(sframe_cnt), 8'd16);
    check("n10_busy", 8'(busy_cnt), 8'd18);

    // Reset during bit 4 aborts the frame.
    clr();
    cap_pulse();
    step(4);
    nCLR = 1'b0;
    step(1);
    check("abort_sframe", {7'd0, m_sframe}, 8'd0);
    check("abort_busy", {7'd0, m_busy}, 8'd0);
    check("abort_sdo", {7'd0, m_sdo}, 8'd0);
    nCLR = 1'b1;
    step(8);
    clr();
    cap_pulse();
    step(12);
    check("after_abort_sframe", 8'(sframe_cnt), 8'd8);
    check("after_abort_seq", seq_m, 8'hA5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
